// File: rtl/aes_sbox_sched.sv
// Issue scheduler for a pipelined masked AES S-box: round-robin over two requesters,
// fresh randomness per issue, credit-bounded in-order result FIFO.
// Optional dummy-op issue on idle cycles is enabled by defining AES_SBOX_SCHED_DUMMY_EN.
module aes_sbox_sched #(
    parameter int SHARES  = 2,
    parameter int LATENCY = 5,   // must be >= 1
    parameter int TAGW    = 4,
    parameter int RNDZ_W  = 22,
    parameter int RNDB_W  = 20
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic                  Req0ValidxSI,
    output logic                  Req0ReadyxSO,
    input  logic [8*SHARES-1:0]   Req0DataxDI,
    input  logic [TAGW-1:0]       Req0TagxDI,
    input  logic                  Req1ValidxSI,
    output logic                  Req1ReadyxSO,
    input  logic [8*SHARES-1:0]   Req1DataxDI,
    input  logic [TAGW-1:0]       Req1TagxDI,
    input  logic                  RndValidxSI,
    output logic                  RndReadyxSO,
    input  logic [RNDZ_W-1:0]     RndZxDI,
    input  logic [RNDB_W-1:0]     RndBxDI,
    output logic [8*SHARES-1:0]   SboxInxDO,
    output logic [RNDZ_W-1:0]     SboxRndZxDO,
    output logic [RNDB_W-1:0]     SboxRndBxDO,
    input  logic [8*SHARES-1:0]   SboxOutxDI,
    output logic                  OutValidxSO,
    input  logic                  OutReadyxSI,
    output logic [8*SHARES-1:0]   OutDataxDO,
    output logic                  OutSrcxSO,
    output logic [TAGW-1:0]       OutTagxDO,
    output logic                  BusyxSO
);

    localparam int DW    = 8 * SHARES;
    localparam int DEPTH = LATENCY + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEMD  = 1 << PW;

    // round-robin pointer: requester preferred when both are valid
    logic                  rr_q, rr_d;

    logic [DW-1:0]         sin_q, sin_d;
    logic [RNDZ_W-1:0]     srz_q, srz_d;
    logic [RNDB_W-1:0]     srb_q, srb_d;

    logic [DEPTH-1:0]             pv_q, pd_q, ps_q;
    logic [DEPTH-1:0][TAGW-1:0]   pt_q;

    logic [DW-1:0]         fd_q [MEMD];
    logic                  fs_q [MEMD];
    logic [TAGW-1:0]       ft_q [MEMD];
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [CW-1:0]         infl;
    logic [CW:0]           occ;
    logic                  credit, go;
    logic                  gnt0, gnt1, rdy0, rdy1, dum;
    logic                  iss, iss_src;
    logic [TAGW-1:0]       iss_tag;
    logic [DW-1:0]         iss_dat;
    logic                  fwr, fpop;

    // Only real operations hold credit; dummies never reach the FIFO.
    always_comb begin
        infl = '0;
        for (int i = 0; i < DEPTH; i++) begin
            infl = infl + CW'(pv_q[i] & ~pd_q[i]);
        end
    end

    assign occ    = {1'b0, cnt_q} + {1'b0, infl};
    assign credit = occ < (CW+1)'(DEPTH);
    assign go     = RstxBI & RndValidxSI & credit;

    assign gnt0 = Req0ValidxSI & (~Req1ValidxSI | ~rr_q);
    assign gnt1 = Req1ValidxSI & (~Req0ValidxSI |  rr_q);
    assign rdy0 = gnt0 & go;
    assign rdy1 = gnt1 & go;

`ifdef AES_SBOX_SCHED_DUMMY_EN
    assign dum = go & ~Req0ValidxSI & ~Req1ValidxSI;
`else
    assign dum = 1'b0;
`endif

    assign iss = rdy0 | rdy1;

    always_comb begin
        iss_src = rdy1;
        iss_tag = rdy1 ? Req1TagxDI : Req0TagxDI;
        iss_dat = rdy1 ? Req1DataxDI : Req0DataxDI;
        if (dum) begin
            iss_src = 1'b0;
            iss_tag = '0;
            iss_dat = RndZxDI[DW-1:0];
        end
    end

    always_comb begin
        rr_d  = rr_q;
        sin_d = sin_q;
        srz_d = srz_q;
        srb_d = srb_q;
        if (iss) begin
            rr_d = ~rdy1;
        end
        if (iss | dum) begin
            sin_d = iss_dat;
            srz_d = RndZxDI;
            srb_d = RndBxDI;
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            rr_q  <= 1'b0;
            sin_q <= '0;
            srz_q <= '0;
            srb_q <= '0;
        end else begin
            rr_q  <= rr_d;
            sin_q <= sin_d;
            srz_q <= srz_d;
            srb_q <= srb_d;
        end
    end

    // Stage DEPTH-1 lines up with the S-box output for the op issued LATENCY+1 edges ago.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            pv_q <= '0;
            pd_q <= '0;
            ps_q <= '0;
            pt_q <= '0;
        end else begin
            pv_q <= {pv_q[DEPTH-2:0], iss | dum};
            pd_q <= {pd_q[DEPTH-2:0], dum};
            ps_q <= {ps_q[DEPTH-2:0], iss_src};
            pt_q <= {pt_q[DEPTH-2:0], iss_tag};
        end
    end

    assign fwr  = pv_q[DEPTH-1] & ~pd_q[DEPTH-1];
    assign fpop = OutValidxSO & OutReadyxSI;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (fwr) begin
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (fpop) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        case ({fwr, fpop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (fwr) begin
            fd_q[wr_q] <= SboxOutxDI;
            fs_q[wr_q] <= ps_q[DEPTH-1];
            ft_q[wr_q] <= pt_q[DEPTH-1];
        end
    end

    assign Req0ReadyxSO = rdy0;
    assign Req1ReadyxSO = rdy1;
    assign RndReadyxSO  = iss | dum;
    assign SboxInxDO    = sin_q;
    assign SboxRndZxDO  = srz_q;
    assign SboxRndBxDO  = srb_q;
    assign OutValidxSO  = cnt_q != '0;
    assign OutDataxDO   = fd_q[rd_q];
    assign OutSrcxSO    = fs_q[rd_q];
    assign OutTagxDO    = ft_q[rd_q];
    assign BusyxSO      = (infl != '0) | (cnt_q != '0);

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched: behavioural S-box pipeline, transaction scoreboard,
// directed scenarios and a randomized phase.
module tb_aes_sbox_sched;
    localparam int L = 5;

    logic        clk = 1'b0, rst = 1'b0;
    logic        v0 = 0, v1 = 0, r0, r1, rv = 0, rr, ov, ordy = 0, osrc, busy;
    logic [15:0] d0 = 0, d1 = 0, sin, sout, odat;
    logic [3:0]  t0 = 0, t1 = 0, otag;
    logic [21:0] rz = 0, srz;
    logic [19:0] rb = 0, srb;

    int nvec = 0, nerr = 0, cyc = 0;

    always #5 clk = ~clk;

    aes_sbox_sched dut (
        .ClkxCI(clk), .RstxBI(rst),
        .Req0ValidxSI(v0), .Req0ReadyxSO(r0), .Req0DataxDI(d0), .Req0TagxDI(t0),
        .Req1ValidxSI(v1), .Req1ReadyxSO(r1), .Req1DataxDI(d1), .Req1TagxDI(t1),
        .RndValidxSI(rv), .RndReadyxSO(rr), .RndZxDI(rz), .RndBxDI(rb),
        .SboxInxDO(sin), .SboxRndZxDO(srz), .SboxRndBxDO(srb), .SboxOutxDI(sout),
        .OutValidxSO(ov), .OutReadyxSI(ordy), .OutDataxDO(odat), .OutSrcxSO(osrc),
        .OutTagxDO(otag), .BusyxSO(busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    // Attached masked S-box: L register stages, output re-shared with RandomZ byte 1.
    logic [15:0] sp [L];
    always @(posedge clk) begin
        sp[0] <= {srz[15:8], sbox(sin[7:0] ^ sin[15:8]) ^ srz[15:8]};
        for (int i = 1; i < L; i++) sp[i] <= sp[i-1];
    end
    assign sout = sp[L-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] val;
        logic       src;
        logic [3:0] tag;
        int         t;
    } exp_t;

    // Reference model: outstanding results as a queue, round-robin preference as a bit.
    initial begin : mon
        exp_t        q[$];
        exp_t        e;
        int          outst;
        bit          nxt, credit, a0, a1, ad, pp, eov;
        logic [15:0] cd, e_sin;
        logic [21:0] crz, e_rz;
        logic [19:0] crb, e_rb;
        logic        csrc;
        logic [3:0]  ctag;
        outst = 0; nxt = 0; e_sin = 0; e_rz = 0; e_rb = 0;
        cd = 0; crz = 0; crb = 0; csrc = 0; ctag = 0;
        forever begin
            @(negedge clk);
            a0 = 0; a1 = 0; ad = 0; pp = 0;
            if (!rst) begin
                q.delete(); outst = 0; nxt = 0; e_sin = 0; e_rz = 0; e_rb = 0;
                chk("rst_rdy", {29'b0, r0, r1, rr}, 0);
                chk("rst_ov", ov, 0);
                chk("rst_busy", busy, 0);
                chk("rst_sin", {sin, srz[15:0]}, 0);
            end else begin
                credit = outst < L + 1;
                a0 = v0 && (!v1 || !nxt) && rv && credit;
                a1 = v1 && (!v0 || nxt) && rv && credit;
`ifdef AES_SBOX_SCHED_DUMMY_EN
                ad = !v0 && !v1 && rv && credit;
`endif
                chk("rdy0", r0, a0);
                chk("rdy1", r1, a1);
                chk("rndrdy", rr, a0 | a1 | ad);
                chk("sbox_in", sin, e_sin);
                chk("sbox_rz", srz, e_rz);
                chk("sbox_rb", srb, e_rb);
                chk("busy", busy, outst != 0);
                eov = q.size() > 0 && q[0].t <= cyc;
                chk("out_valid", ov, eov);
                if (ov && eov) begin
                    chk("out_data", odat[7:0] ^ odat[15:8], q[0].val);
                    chk("out_src", osrc, q[0].src);
                    chk("out_tag", otag, q[0].tag);
                    pp = ordy;
                end
                cd   = a0 ? d0 : (a1 ? d1 : rz[15:0]);
                csrc = a1;
                ctag = a1 ? t1 : t0;
                crz  = rz;
                crb  = rb;
            end
            @(posedge clk);
            cyc++;
            if (pp) begin
                void'(q.pop_front());
                outst--;
            end
            if (a0 || a1) begin
                e.val = sbox(cd[7:0] ^ cd[15:8]);
                e.src = csrc;
                e.tag = ctag;
                e.t   = cyc + L + 1;
                q.push_back(e);
                outst++;
                nxt = a0;
            end
            if (a0 || a1 || ad) begin
                e_sin = cd; e_rz = crz; e_rb = crb;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rz = 22'($urandom);
        rb = 20'($urandom);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n, k;
        logic [15:0] saved;
        repeat (3) tick();
        rst = 1;
        tick();

        // Single op: S(0x53) = 0xED, result LATENCY+1 edges after accept.
        ordy = 1; rv = 1; v0 = 1; d0 = {8'hF6, 8'hA5}; t0 = 4'h3;
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (r0) break;
            tick();
        end
        chk("t1_acc", r0, 1);
        tick();
        v0 = 0;
        n = 0;
        @(negedge clk);
        while (!ov && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1_lat", n, 6);
        chk("t1_data", odat[7:0] ^ odat[15:8], 8'hED);
        chk("t1_src", osrc, 0);
        chk("t1_tag", otag, 4'h3);
        repeat (5) tick();

        // Fresh reset, then both requesters contend: strict alternation from requester 0.
        rst = 0; tick(); tick(); rst = 1;
        repeat (8) tick();
        v0 = 1; v1 = 1; k = 0;
        for (int c = 0; c < 60 && k < 8; c++) begin
            @(negedge clk);
            if (r0 || r1) begin
                chk("t2_gnt", r1, k % 2);
                k++;
            end
            tick();
            d0 = 16'($urandom); d1 = 16'($urandom);
            t0 = 4'($urandom); t1 = 4'($urandom);
        end
        chk("t2_cnt", k, 8);
        v0 = 0; v1 = 0;
        repeat (15) tick();

        // Backpressure: exactly LATENCY+1 accepts, then drain in order.
        ordy = 0; v0 = 1; k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (r0) k++;
            tick();
            d0 = 16'($urandom); t0 = 4'($urandom);
        end
        chk("t3_acc", k, 6);
        @(negedge clk);
        chk("t3_stall", r0, 0);
        tick();
        v0 = 0; ordy = 1; k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ov) k++;
            tick();
        end
        chk("t3_drain", k, 6);

        // No randomness: nothing issues, S-box input holds.
        v0 = 1; v1 = 1; rv = 0;
        @(negedge clk);
        saved = sin;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_rdy", {30'b0, r0, r1}, 0);
            chk("t4_rnd", rr, 0);
            chk("t4_hold", sin, saved);
            tick();
        end
        v0 = 0; v1 = 0; rv = 1;
        repeat (10) tick();

        // Reset mid-flight discards in-flight work.
        v0 = 1; d0 = 16'($urandom);
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (r0) break;
            tick();
        end
        tick();
        v0 = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("t5_busy_pre", busy, 1);
        tick();
        rst = 0;
        @(negedge clk);
        chk("t5_ov_rst", ov, 0);
        chk("t5_busy_rst", busy, 0);
        tick();
        rst = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t5_ov", ov, 0);
            chk("t5_busy", busy, 0);
            tick();
        end

        // Idle with randomness available.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
`ifdef AES_SBOX_SCHED_DUMMY_EN
            chk("t6_rnd", rr, 1);
`else
            chk("t6_rnd", rr, 0);
`endif
            chk("t6_ov", ov, 0);
            tick();
        end

        // Randomized traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 400; c++) begin
            v0 = ($urandom % 3) != 0;
            v1 = ($urandom % 3) != 0;
            rv = ($urandom % 4) != 0;
            ordy = 1'($urandom);
            d0 = 16'($urandom); d1 = 16'($urandom);
            t0 = 4'($urandom); t1 = 4'($urandom);
            tick();
        end
        v0 = 0; v1 = 0; rv = 1; ordy = 1;
        repeat (20) tick();
        @(negedge clk);
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/aes_sbox_sched.md
AES_SBOX_SCHED -- requirements
Module: aes_sbox_sched

Interface
REQ-001 SHALL have parameter SHARES, default 2, number of Boolean shares per byte.
REQ-002 SHALL have parameter LATENCY, default 5, fixed register depth of the attached pipelined masked S-box.
REQ-003 SHALL have parameter TAGW, default 4, requester tag width.
REQ-004 SHALL have parameter RNDZ_W, default 22, RandomZ width; RNDZ_W >= 8*SHARES.
REQ-005 SHALL have parameter RNDB_W, default 20, RandomB width.
REQ-006 SHALL have ports (one clock; reset is asynchronous and active-low):
ClkxCI  in  1  clock, rising edge
RstxBI  in  1  asynchronous active-low reset
Req0ValidxSI / Req1ValidxSI  in  1  operand valid, requester 0/1
Req0ReadyxSO / Req1ReadyxSO  out  1  operand accepted
Req0DataxDI / Req1DataxDI  in  8*SHARES  shared input byte
Req0TagxDI / Req1TagxDI  in  TAGW  tag returned with result
RndValidxSI  in  1  fresh randomness available
RndReadyxSO  out  1  randomness consumed this cycle
RndZxDI  in  RNDZ_W  fresh RandomZ
RndBxDI  in  RNDB_W  fresh RandomB
SboxInxDO  out  8*SHARES  S-box shared input
SboxRndZxDO  out  RNDZ_W  S-box RandomZ
SboxRndBxDO  out  RNDB_W  S-box RandomB
SboxOutxDI  in  8*SHARES  S-box shared output
OutValidxSO  out  1  result valid
OutReadyxSI  in  1  result accepted
OutDataxDO  out  8*SHARES  shared result
OutSrcxSO  out  1  originating requester
OutTagxDO  out  TAGW  originating tag
BusyxSO  out  1  work in flight or buffered

Function
REQ-007 SHALL arbitrate round-robin: if both valid, grant the requester not last issued; if one valid, grant it; pointer updates only on a real issue.
REQ-008 SHALL assert ReqNReadyxSO only when N granted, RndValidxSI=1, and credit available; RndReadyxSO=1 on every issue.
REQ-009 SHALL define credit available as fifo_count + inflight < LATENCY+1; result FIFO depth is LATENCY+1.
REQ-010 SHALL, on issue at edge k, register operand/RndZ/RndB onto SboxInxDO/SboxRndZxDO/SboxRndBxDO; outputs hold their value when no issue occurs (no toggling).
REQ-011 SHALL track each issue through a LATENCY+1 deep shift register of {valid, dummy, src, tag}; SboxOutxDI written to FIFO at edge k+1+LATENCY.
REQ-012 SHALL present the FIFO head first-word-fall-through; OutValid rises LATENCY+1 cycles after accept when FIFO empty.
REQ-013 SHALL deliver results strictly in issue order; pop on OutValid & OutReady.
REQ-014 SHALL allow simultaneous FIFO write and pop; count unchanged, no loss.
REQ-015 SHALL not count the same-cycle pop when computing credit (conservative).
REQ-016 SHALL drive BusyxSO = (inflight != 0) | (fifo_count != 0).
REQ-017 SHALL never issue with RndValidxSI=0; randomness reused across two issues is forbidden.

Reset
REQ-018 SHALL on RstxBI=0 immediately clear: inflight shift register, FIFO (count 0), round-robin pointer (requester 0 next), SboxInxDO/SboxRndZxDO/SboxRndBxDO=0, all ready/valid outputs=0, BusyxSO=0.
REQ-019 SHALL discard results in flight when reset asserts mid-operation; none appear after deassertion.

Configuration
REQ-020 SHALL support macro AES_SBOX_SCHED_DUMMY_EN.
REQ-021 With AES_SBOX_SCHED_DUMMY_EN defined: when no requester is valid, RndValidxSI=1 and credit available, SHALL issue a dummy op (data = RndZxDI[8*SHARES-1:0]), assert RndReadyxSO, mark entry dummy, not write it to the FIFO, not move the pointer; dummies consume no credit after leaving the pipeline.
REQ-022 Without the macro: idle cycles issue nothing, RndReadyxSO=0, S-box inputs hold.

Verification
REQ-023 Req0 data shares {0x53^0xA5, 0xA5}, tag 0x3, rnd valid, OutReady=1 -> OutValid after 6 cycles, shares XOR = 0xED, OutSrc=0, OutTag=0x3.
REQ-024 Both requesters valid 8 cycles after reset -> grants 0,1,0,1,0,1,0,1; results in same order.
REQ-025 OutReady=0, req0 always valid -> exactly 6 accepts then Req0Ready=0; OutReady=1 -> 6 results in order, none lost.
REQ-026 RndValid=0 with both requesters valid -> both readies 0, RndReady=0, SboxInxDO unchanged.
REQ-027 Reset asserted 3 cycles after accept -> OutValid=0, BusyxSO=0 immediately and for 10 cycles after release.
REQ-028 Idle, RndValid=1, 10 cycles -> with DUMMY_EN RndReady=1 each cycle, OutValid=0; without, RndReady=0.
